// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use interlock,
// multi-cycle EX sequencing (DIV/DIVU), pipeline flush and a stall counter.
module pipe_ctrl #(
  parameter int MC_CYCLES = 34,
  parameter int MC_CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  input  logic        ex_is_load_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_mc_req_i,
  input  logic        flush_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        mc_start_o,
  output logic        mc_busy_o,
  output logic        mc_done_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [MC_CNT_W-1:0] CNT_LOAD = MC_CNT_W'(MC_CYCLES - 1);
  localparam logic [5:0] LU_STALL = 6'b000111;
  localparam logic [5:0] MC_STALL = 6'b001111;

  state_t              state;
  logic [MC_CNT_W-1:0] cnt;
  logic                load_use_hit;
  logic                mc_stall;

  // Register $0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use_hit = ex_is_load_i & ex_wreg_i & (ex_waddr_i != 5'd0) &
                        ((id_reg1_read_i & (id_reg1_addr_i == ex_waddr_i)) |
                         (id_reg2_read_i & (id_reg2_addr_i == ex_waddr_i)));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stall_o    = '0;
    flush_o    = 1'b0;
    mc_start_o = 1'b0;
    mc_busy_o  = 1'b0;
    mc_done_o  = 1'b0;
    mc_stall   = 1'b0;
    if (!rst) begin
      mc_busy_o = (state != IDLE);
      if (flush_i) begin
        flush_o = 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            mc_start_o = ex_mc_req_i;
            mc_stall   = ex_mc_req_i;
          end
          RUN:     mc_stall  = 1'b1;
          DONE:    mc_done_o = 1'b1;
          default: mc_stall  = 1'b0;
        endcase
        stall_o = (load_use_hit ? LU_STALL : 6'b0) | (mc_stall ? MC_STALL : 6'b0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (stall_o[2] && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;

      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ex_mc_req_i) begin
              state <= RUN;
              cnt   <= CNT_LOAD;
            end
          end
          RUN: begin
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - MC_CNT_W'(1);
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use vector table plus hand-written
// multi-cycle, flush, reset and back-to-back sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i, id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
  logic        ex_is_load_i, ex_wreg_i, ex_mc_req_i, flush_i;
  logic [4:0]  ex_waddr_i;

  logic [5:0]  stall_o, stall1_o;
  logic        flush_o, mc_start_o, mc_busy_o, mc_done_o;
  logic        flush1_o, mc_start1_o, mc_busy1_o, mc_done1_o;
  logic [31:0] stall_cnt_o, stall_cnt1_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_CYCLES(34), .MC_CNT_W(6)) u_dut (
    .clk(clk), .rst(rst),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i),
    .ex_mc_req_i(ex_mc_req_i), .flush_i(flush_i),
    .stall_o(stall_o), .flush_o(flush_o), .mc_start_o(mc_start_o),
    .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_ctrl #(.MC_CYCLES(1), .MC_CNT_W(6)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i),
    .ex_mc_req_i(ex_mc_req_i), .flush_i(flush_i),
    .stall_o(stall1_o), .flush_o(flush1_o), .mc_start_o(mc_start1_o),
    .mc_busy_o(mc_busy1_o), .mc_done_o(mc_done1_o), .stall_cnt_o(stall_cnt1_o)
  );

  typedef struct {
    logic       r1_rd;
    logic [4:0] r1_a;
    logic       r2_rd;
    logic [4:0] r2_a;
    logic       ld;
    logic       wreg;
    logic [4:0] wa;
    logic [5:0] exp_stall;
  } lu_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_reg1_read_i = 0; id_reg1_addr_i = 0;
    id_reg2_read_i = 0; id_reg2_addr_i = 0;
    ex_is_load_i = 0; ex_wreg_i = 0; ex_waddr_i = 0;
    ex_mc_req_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  lu_vec_t vecs[9];
  int      exp_cnt;
  logic    done_seen;

  initial begin
    vecs[0] = '{1, 5'd5,  0, 5'd0,  1, 1, 5'd5,  6'b000111};
    vecs[1] = '{1, 5'd0,  0, 5'd0,  1, 1, 5'd5,  6'b000000};
    vecs[2] = '{1, 5'd0,  0, 5'd0,  1, 1, 5'd0,  6'b000000};
    vecs[3] = '{0, 5'd1,  1, 5'd5,  1, 1, 5'd5,  6'b000111};
    vecs[4] = '{0, 5'd5,  0, 5'd5,  1, 1, 5'd5,  6'b000000};
    vecs[5] = '{1, 5'd5,  0, 5'd0,  0, 1, 5'd5,  6'b000000};
    vecs[6] = '{1, 5'd5,  0, 5'd0,  1, 0, 5'd5,  6'b000000};
    vecs[7] = '{1, 5'd31, 1, 5'd7,  1, 1, 5'd7,  6'b000111};
    vecs[8] = '{1, 5'd31, 0, 5'd7,  1, 1, 5'd31, 6'b000111};

    do_reset();
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_busy", 32'(mc_busy_o), 32'd0);
    check("reset_flush", 32'(flush_o), 32'd0);
    check("reset_cnt", stall_cnt_o, 32'd0);

    // T1: load-use table, applied one vector per cycle from IDLE
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      id_reg1_read_i = vecs[i].r1_rd; id_reg1_addr_i = vecs[i].r1_a;
      id_reg2_read_i = vecs[i].r2_rd; id_reg2_addr_i = vecs[i].r2_a;
      ex_is_load_i = vecs[i].ld; ex_wreg_i = vecs[i].wreg; ex_waddr_i = vecs[i].wa;
      #1;
      check($sformatf("lu_stall[%0d]", i), 32'(stall_o), 32'(vecs[i].exp_stall));
      check($sformatf("lu_start[%0d]", i), 32'(mc_start_o), 32'd0);
      if (vecs[i].exp_stall[2]) exp_cnt++;
      next_cycle();
    end
    clear_inputs();
    #1;
    check("lu_stall_cnt", stall_cnt_o, 32'(exp_cnt));

    // T2: full 34-cycle multi-cycle op
    do_reset();
    ex_mc_req_i = 1'b1;
    #1;
    check("t2_start", 32'(mc_start_o), 32'd1);
    check("t2_start_stall", 32'(stall_o), 32'b001111);
    check("t2_start_busy", 32'(mc_busy_o), 32'd0);
    next_cycle();
    ex_mc_req_i = 1'b0;
    #1;
    for (int i = 0; i < 34; i++) begin
      check($sformatf("t2_run_stall[%0d]", i), 32'(stall_o), 32'b001111);
      check($sformatf("t2_run_busy[%0d]", i), 32'({mc_busy_o, mc_start_o, mc_done_o}), 32'b100);
      next_cycle();
    end
    check("t2_done", 32'(mc_done_o), 32'd1);
    check("t2_done_stall", 32'(stall_o), 32'd0);
    check("t2_done_busy", 32'(mc_busy_o), 32'd1);
    next_cycle();
    check("t2_idle_busy", 32'(mc_busy_o), 32'd0);
    check("t2_idle_done", 32'(mc_done_o), 32'd0);
    check("t2_stall_cnt", stall_cnt_o, 32'd35);

    // T3: flush on the 10th RUN cycle
    ex_mc_req_i = 1'b1;
    next_cycle();
    ex_mc_req_i = 1'b0;
    for (int i = 0; i < 9; i++) next_cycle();
    flush_i = 1'b1;
    #1;
    check("t3_flush_o", 32'(flush_o), 32'd1);
    check("t3_flush_stall", 32'(stall_o), 32'd0);
    next_cycle();
    flush_i = 1'b0;
    #1;
    check("t3_busy_after", 32'(mc_busy_o), 32'd0);
    check("t3_stall_cnt", stall_cnt_o, 32'd45);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mc_done_o) done_seen = 1'b1;
      next_cycle();
    end
    check("t3_no_done", 32'(done_seen), 32'd0);

    // T4: reset asserted on RUN cycle 5, with hazards and a request present
    ex_mc_req_i = 1'b1;
    next_cycle();
    ex_mc_req_i = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();
    rst = 1'b1;
    ex_mc_req_i = 1'b1;
    flush_i = 1'b1;
    id_reg1_read_i = 1; id_reg1_addr_i = 5'd3;
    ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = 5'd3;
    #1;
    check("t4_rst_outs",
          32'({stall_o, flush_o, mc_start_o, mc_busy_o, mc_done_o}), 32'd0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("t4_busy", 32'(mc_busy_o), 32'd0);
    check("t4_stall_cnt", stall_cnt_o, 32'd0);

    // T5: load-use hit coincident with MC start
    id_reg2_read_i = 1; id_reg2_addr_i = 5'd9;
    ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = 5'd9;
    ex_mc_req_i = 1;
    #1;
    check("t5_stall", 32'(stall_o), 32'b001111);
    check("t5_start", 32'(mc_start_o), 32'd1);

    // T6: MC_CYCLES=1 instance, request held high for back-to-back ops
    do_reset();
    ex_mc_req_i = 1'b1;
    #1;
    check("t6_start1", 32'({mc_start1_o, stall1_o}), 32'b1001111);
    next_cycle();
    check("t6_run", 32'({mc_start1_o, mc_done1_o, stall1_o}), 32'b00001111);
    next_cycle();
    check("t6_done", 32'({mc_start1_o, mc_done1_o, stall1_o}), 32'b01000000);
    next_cycle();
    check("t6_start2", 32'({mc_start1_o, mc_done1_o, stall1_o}), 32'b10001111);
    check("t6_stall_cnt", stall_cnt1_o, 32'd2);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
